// File: rtl/ayatsuki_unified_mem_pkg.sv
// ayatsuki_unified_mem_pkg
//   Shared definitions for the AyaTsuki unified instruction/data memory:
//   default widths, the response field layout {valid, err, data}, the legal
//   read-latency range and the arbiter grant encoding.
package ayatsuki_unified_mem_pkg;

   localparam int unsigned DEF_DATA_W      = 32;
   localparam int unsigned DEF_DEPTH_BYTES = 2048;
   localparam int unsigned DEF_ADDR_W      = 32;
   localparam int unsigned DEF_RD_LATENCY  = 1;
   localparam int unsigned DEF_STARVE_MAX  = 3;

   localparam int unsigned RD_LATENCY_MIN  = 1;
   localparam int unsigned RD_LATENCY_MAX  = 4;

   // Response word layout, MSB first: {valid, err, data[DATA_W-1:0]}
   localparam int unsigned RSP_CTRL_W      = 2;

   function automatic int unsigned rsp_w(input int unsigned data_w);
      return data_w + RSP_CTRL_W;
   endfunction

   function automatic int unsigned rsp_valid_bit(input int unsigned data_w);
      return data_w + 1;
   endfunction

   function automatic int unsigned rsp_err_bit(input int unsigned data_w);
      return data_w;
   endfunction

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_DATA = 2'd1,
      GNT_INST = 2'd2
   } grant_e;

endpackage

// File: rtl/ayatsuki_mem_rsp_pipe.sv
// ayatsuki_mem_rsp_pipe
//   Fixed-depth response shift pipeline carrying {valid, err, data}.
//   A response entering at a clock edge appears on the outputs LATENCY
//   cycles later; the whole pipeline clears asynchronously on reset.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid_i/err_i/data_i   response launched at this edge
//   out_valid_o/err_o/data_o  registered response leaving the pipeline
module ayatsuki_mem_rsp_pipe
   import ayatsuki_unified_mem_pkg::*;
#(
   parameter int unsigned DATA_W  = DEF_DATA_W,
   parameter int unsigned LATENCY = DEF_RD_LATENCY
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid_i,
   input  logic              in_err_i,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              out_valid_o,
   output logic              out_err_o,
   output logic [DATA_W-1:0] out_data_o
);

   // Out-of-range latency values are clamped into the supported window.
   localparam int unsigned LAT = (LATENCY < RD_LATENCY_MIN) ? RD_LATENCY_MIN :
                                 (LATENCY > RD_LATENCY_MAX) ? RD_LATENCY_MAX : LATENCY;
   localparam int unsigned RW  = rsp_w(DATA_W);
   localparam int unsigned VB  = rsp_valid_bit(DATA_W);
   localparam int unsigned EB  = rsp_err_bit(DATA_W);

   logic [RW-1:0] stage_q [LAT];
   logic [RW-1:0] stage_d [LAT];

   // Next-state: pack the new response (idle slots carry all zeros) and shift.
   always_comb begin
      for (int unsigned i = 0; i < LAT; i++) begin
         stage_d[i] = '0;
      end
      if (in_valid_i) begin
         stage_d[0][VB]           = 1'b1;
         stage_d[0][EB]           = in_err_i;
         stage_d[0][DATA_W-1:0]   = in_data_i;
      end else begin
         stage_d[0] = '0;
      end
      for (int unsigned i = 1; i < LAT; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   // Pipeline registers; reset drops everything in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < LAT; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < LAT; i++) begin
            stage_q[i] <= stage_d[i];
         end
      end
   end

   assign out_valid_o = stage_q[LAT-1][VB];
   assign out_err_o   = stage_q[LAT-1][EB];
   assign out_data_o  = stage_q[LAT-1][DATA_W-1:0];

endmodule

// File: rtl/ayatsuki_unified_mem.sv
// ayatsuki_unified_mem
//   Unified big-endian instruction/data memory. One array access per cycle
//   is shared between a read-only fetch port and a read/write data port by a
//   data-priority arbiter with an instruction starvation guard. Responses
//   return RD_LATENCY cycles after the grant edge through per-port pipelines.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   inst_req_i/inst_addr_i           fetch request and byte address
//   inst_ready_o                     fetch granted this cycle (combinational)
//   inst_valid_o/err_o/data_o        fetch response
//   mem_enable_i/r_enable_i/w_enable_i  data request qualifiers
//   mem_addr_i/w_data_i/byte_en_i    data byte address, write data, lanes
//   mem_ready_o                      data request granted (combinational)
//   mem_rsp_valid_o/err_o/r_data_o   data response (writes return data 0)
module ayatsuki_unified_mem
   import ayatsuki_unified_mem_pkg::*;
#(
   parameter int unsigned DATA_W      = DEF_DATA_W,
   parameter int unsigned DEPTH_BYTES = DEF_DEPTH_BYTES,
   parameter int unsigned ADDR_W      = DEF_ADDR_W,
   parameter int unsigned RD_LATENCY  = DEF_RD_LATENCY,
   parameter int unsigned STARVE_MAX  = DEF_STARVE_MAX
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                inst_req_i,
   input  logic [ADDR_W-1:0]   inst_addr_i,
   output logic                inst_ready_o,
   output logic                inst_valid_o,
   output logic                inst_err_o,
   output logic [DATA_W-1:0]   inst_data_o,
   input  logic                mem_enable_i,
   input  logic                mem_r_enable_i,
   input  logic                mem_w_enable_i,
   input  logic [ADDR_W-1:0]   mem_addr_i,
   input  logic [DATA_W-1:0]   mem_w_data_i,
   input  logic [DATA_W/8-1:0] mem_byte_en_i,
   output logic                mem_ready_o,
   output logic                mem_rsp_valid_o,
   output logic                mem_rsp_err_o,
   output logic [DATA_W-1:0]   mem_r_data_o
);

   localparam int unsigned NB          = DATA_W / 8;
   localparam int unsigned OFF_W       = $clog2(NB);
   localparam int unsigned DEPTH_WORDS = DEPTH_BYTES / NB;
   localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS);
   localparam int unsigned SC_W        = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH_BYTES - NB);
   localparam logic [SC_W-1:0]   STARVE_LIM = SC_W'(STARVE_MAX);

   // Lane NB-1 (MSBs) holds the lowest byte address of each word.
   logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

   logic [SC_W-1:0]   starve_q, starve_d;
   grant_e            grant_s;
   logic              data_req_s;
   logic [ADDR_W-1:0] gnt_addr_s;
   logic              gnt_err_s;
   logic [IDX_W-1:0]  gnt_idx_s;
   logic [DATA_W-1:0] rd_word_s;
   logic [DATA_W-1:0] rsp_data_s;
   logic              wr_commit_s;

   assign data_req_s = mem_enable_i & (mem_r_enable_i | mem_w_enable_i);

   // Arbiter: data wins unless the fetch port has hit its starvation limit.
   always_comb begin
      grant_s = GNT_NONE;
      if (!rst_n) begin
         grant_s = GNT_NONE;
      end else if (inst_req_i && (!data_req_s || (starve_q == STARVE_LIM))) begin
         grant_s = GNT_INST;
      end else if (data_req_s) begin
         grant_s = GNT_DATA;
      end else begin
         grant_s = GNT_NONE;
      end
   end

   // Starvation count: consecutive cycles the fetch port waited and lost.
   always_comb begin
      starve_d = starve_q;
      if (!inst_req_i || (grant_s == GNT_INST)) begin
         starve_d = '0;
      end else if (starve_q != STARVE_LIM) begin
         starve_d = starve_q + SC_W'(1);
      end else begin
         starve_d = starve_q;
      end
   end

   // Starvation counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end

   // Address of whichever port owns the array this cycle.
   always_comb begin
      gnt_addr_s = mem_addr_i;
      case (grant_s)
         GNT_INST: gnt_addr_s = inst_addr_i;
         GNT_DATA: gnt_addr_s = mem_addr_i;
         default:  gnt_addr_s = mem_addr_i;
      endcase
   end

   // Full-width compare so addresses past the array never alias into it.
   assign gnt_err_s   = (|gnt_addr_s[OFF_W-1:0]) | (gnt_addr_s > LAST_ADDR);
   assign gnt_idx_s   = gnt_addr_s[OFF_W +: IDX_W];
   assign rd_word_s   = mem_q[gnt_idx_s];
   assign wr_commit_s = (grant_s == GNT_DATA) & mem_w_enable_i & ~gnt_err_s;

   // Response data: errors and writes return zero.
   always_comb begin
      rsp_data_s = '0;
      if ((grant_s == GNT_INST) && !gnt_err_s) begin
         rsp_data_s = rd_word_s;
      end else if ((grant_s == GNT_DATA) && !gnt_err_s && !mem_w_enable_i) begin
         rsp_data_s = rd_word_s;
      end else begin
         rsp_data_s = '0;
      end
   end

   // Array write, per enabled lane; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_commit_s) begin
         for (int unsigned l = 0; l < NB; l++) begin
            if (mem_byte_en_i[l]) begin
               mem_q[gnt_idx_s][8*l +: 8] <= mem_w_data_i[8*l +: 8];
            end
         end
      end
   end

   assign inst_ready_o = (grant_s == GNT_INST);
   assign mem_ready_o  = (grant_s == GNT_DATA);

   ayatsuki_mem_rsp_pipe #(
      .DATA_W  (DATA_W),
      .LATENCY (RD_LATENCY)
   ) u_inst_pipe (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (grant_s == GNT_INST),
      .in_err_i    (gnt_err_s),
      .in_data_i   (rsp_data_s),
      .out_valid_o (inst_valid_o),
      .out_err_o   (inst_err_o),
      .out_data_o  (inst_data_o)
   );

   ayatsuki_mem_rsp_pipe #(
      .DATA_W  (DATA_W),
      .LATENCY (RD_LATENCY)
   ) u_data_pipe (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (grant_s == GNT_DATA),
      .in_err_i    (gnt_err_s),
      .in_data_i   (rsp_data_s),
      .out_valid_o (mem_rsp_valid_o),
      .out_err_o   (mem_rsp_err_o),
      .out_data_o  (mem_r_data_o)
   );

endmodule

// File: doc/ayatsuki_unified_mem.md
# ayatsuki_unified_mem

Parametrised unified instruction/data memory for the AyaTsuki core, replacing the separate fixed 2 KiB ROM and RAM models with one synthesizable byte-addressed array. It serves a read-only instruction port and a read/write data port with byte enables. Both ports share a single array access per cycle through a data-priority arbiter with an instruction starvation guard. Responses return through a configurable-latency pipeline, and errors are flagged for misaligned or out-of-range addresses.

## Interface
Parameters:
- DATA_W, 32: word width in bits; must be 32 or 64.
- DEPTH_BYTES, 2048: array size in bytes; must be a power of two and a multiple of DATA_W/8.
- ADDR_W, 32: address width of both ports.
- RD_LATENCY, 1: number of cycles from request acceptance to response; legal range 1..4.
- STARVE_MAX, 3: number of consecutive denied instruction cycles before the instruction port is forced to win.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- inst_req_i  in  1  instruction fetch request.
- inst_addr_i  in  ADDR_W  fetch byte address.
- inst_ready_o  out  1  fetch accepted this cycle.
- inst_valid_o  out  1  fetch response valid.
- inst_err_o  out  1  fetch response error.
- inst_data_o  out  DATA_W  fetched word.
- mem_enable_i  in  1  data request qualifier.
- mem_r_enable_i  in  1  data read.
- mem_w_enable_i  in  1  data write.
- mem_addr_i  in  ADDR_W  data byte address.
- mem_w_data_i  in  DATA_W  write data.
- mem_byte_en_i  in  DATA_W/8  byte enables; bit DATA_W/8-1 selects the MSB lane.
- mem_ready_o  out  1  data request accepted.
- mem_rsp_valid_o  out  1  data response valid; one per accepted read or write.
- mem_rsp_err_o  out  1  data response error.
- mem_r_data_o  out  DATA_W  read data.

## Operation
- Byte order is big-endian: the byte at addr maps to data bits [DATA_W-1:DATA_W-8], and each following address maps to the next lower byte.
- Data request = mem_enable_i & (mem_r_enable_i | mem_w_enable_i). If read and write are both high, the write is performed and the response is that of a write.
- Arbitration, one grant per cycle:
  - A data request wins by default.
  - The instruction port wins when starve_cnt == STARVE_MAX.
  - starve_cnt increments on every cycle with inst_req_i high and not granted.
  - starve_cnt clears on every instruction grant, and on every cycle with inst_req_i low.
- ready_o is combinational, high in the cycle of grant. Requesters hold their request until ready is seen.
- Error condition: address not aligned to DATA_W/8, or addr > DEPTH_BYTES - DATA_W/8.
  - A request with an error is still granted.
  - It produces no array access and no write.
  - Its response carries err=1 and data=0.
- Writes commit at the grant edge, per enabled byte lane; disabled lanes are unchanged.
- A read granted in the cycle after a write to the same word returns the new data.
- A write response carries data=0.
- Array contents are not reset; the array powers up as X in simulation, and benches preload it with $readmemb.

## Timing
- Response latency is exactly RD_LATENCY cycles after the grant edge. Throughput is one grant per cycle in total across both ports.
- Responses within each port are returned in order. The two ports' response pipelines are independent.
- Reset values: all valid, err, and data outputs 0; starve_cnt 0; pipeline stages empty. Ready outputs follow the requests combinationally once rst_n is high, and are 0 while in reset.
- Reset asserted mid-flight: all in-flight responses are discarded and no response is emitted after reset releases. A write already committed stays in the array.
- Boundaries:
  - The last legal word (DEPTH_BYTES - DATA_W/8) is an ordinary access.
  - The next word address errors.
  - Addresses above DEPTH_BYTES do not wrap.

## Structure
- The shared defines header carries:
  - default widths;
  - the response field layout (valid, err, data);
  - the legal RD_LATENCY range.
- Sub-module ayatsuki_mem_rsp_pipe: an RD_LATENCY-deep valid/err/data shift pipeline with asynchronous clear, instantiated once per port.
- The arbiter, starvation counter, and array live in the top module.

## Test plan
- Preload word 0x11223344 at addr 0x10, then read it with RD_LATENCY=2 -> mem_rsp_valid_o high 2 cycles after grant, data 0x11223344, err 0.
- Write 0xAABBCCDD to addr 0x10 with mem_byte_en_i=4'b0101, then read it back -> 0x11BB33DD.
- Hold data and inst requests continuously with STARVE_MAX=3 -> inst granted on the 4th cycle, then 3 data grants, repeating.
- Read at addr 0x7FC -> valid data. Read at 0x800 or 0x6 -> err 1, data 0. A write to 0x800 leaves the array unchanged.
- Drop rst_n with 2 reads in flight -> no valid pulses follow; written data persists across the reset.
- Set DATA_W=64, DEPTH_BYTES=4096 -> aligned 8-byte access works, and the byte-enable lane order is checked.
